// File: rtl/cfu_pkg.sv
// Shared constants for the CFU MAC sequencer: CPU opcodes, MAC engine
// function ids, the illegal-opcode response word and the FSM state encoding.
package cfu_pkg;

    // CPU opcodes carried in cmd_payload_function_id[2:0]
    localparam logic [2:0] OP_SET_OFF = 3'd0;
    localparam logic [2:0] OP_RUN     = 3'd1;

    // MAC engine function ids
    localparam logic [9:0] MAC_FN_ACC   = {7'd0, 3'd0};
    localparam logic [9:0] MAC_FN_CLEAR = {7'd0, 3'd2};

    // Response word returned for any unsupported opcode
    localparam logic [31:0] ILLEGAL_RSP = 32'hFFFF_FFFF;

    // Sequencer FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_CLEAR    = 3'd1;
    localparam state_t ST_CLR_WAIT = 3'd2;
    localparam state_t ST_FETCH    = 3'd3;
    localparam state_t ST_LOAD     = 3'd4;
    localparam state_t ST_ISSUE    = 3'd5;
    localparam state_t ST_MWAIT    = 3'd6;
    localparam state_t ST_RESP     = 3'd7;

endpackage

// File: rtl/cfu_mac_sequencer.sv
// CFU MAC sequencer: turns one CPU RUN command into a full dot product by
// clearing the MAC accumulator, streaming N operand words from the operand
// buffer into the MAC engine one at a time, and returning the final sum.
module cfu_mac_sequencer
    import cfu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_payload_function_id,
    input  logic [31:0]       cmd_payload_inputs_0,
    input  logic [31:0]       cmd_payload_inputs_1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_payload_outputs_0,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [31:0]       buf_rd_a,
    input  logic [31:0]       buf_rd_b,
    output logic              mac_cmd_valid,
    input  logic              mac_cmd_ready,
    output logic [9:0]        mac_func_id,
    output logic [31:0]       mac_in0,
    output logic [31:0]       mac_in1,
    input  logic              mac_rsp_valid,
    output logic              mac_rsp_ready,
    input  logic [31:0]       mac_rsp_out
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [15:0]         offset_q, offset_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic [31:0]         op_a_q, op_a_d;
    logic [31:0]         op_b_q, op_b_d;
    logic                unused_bits;

    // Command fields that carry no meaning for this block
    assign unused_bits = ^{cmd_payload_function_id[9:3],
                           cmd_payload_inputs_0[31:16],
                           cmd_payload_inputs_1[31:LEN_W]};

    // Next-state and datapath-register update for the sequencing FSM
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        offset_d   = offset_q;
        rsp_data_d = rsp_data_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_payload_function_id[2:0])
                        OP_SET_OFF: begin
                            offset_d   = cmd_payload_inputs_0[15:0];
                            rsp_data_d = 32'd0;
                            state_d    = ST_RESP;
                        end
                        OP_RUN: begin
                            addr_d  = cmd_payload_inputs_0[ADDR_W-1:0];
                            cnt_d   = cmd_payload_inputs_1[LEN_W-1:0];
                            state_d = ST_CLEAR;
                        end
                        default: begin
                            rsp_data_d = ILLEGAL_RSP;
                            state_d    = ST_RESP;
                        end
                    endcase
                end
            end
            ST_CLEAR: begin
                if (mac_cmd_ready) begin
                    state_d = ST_CLR_WAIT;
                end
            end
            ST_CLR_WAIT: begin
                if (mac_rsp_valid) begin
                    if (cnt_q == '0) begin
                        rsp_data_d = mac_rsp_out;
                        state_d    = ST_RESP;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                // Address wraps naturally at the buffer width
                addr_d  = addr_q + ADDR_W'(1);
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                op_a_d  = buf_rd_a;
                op_b_d  = buf_rd_b;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (mac_cmd_ready) begin
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = ST_MWAIT;
                end
            end
            ST_MWAIT: begin
                if (mac_rsp_valid) begin
                    rsp_data_d = mac_rsp_out;
                    state_d    = (cnt_q == '0) ? ST_RESP : ST_FETCH;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and response registers, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            offset_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            offset_q   <= offset_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Operand holding registers; only observed while ISSUE drives them out
    always_ff @(posedge clk) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
    end

    assign cmd_ready             = (state_q == ST_IDLE);
    assign rsp_valid             = (state_q == ST_RESP);
    assign rsp_payload_outputs_0 = rsp_data_q;
    assign buf_rd_en             = (state_q == ST_FETCH);
    assign buf_rd_addr           = addr_q;
    assign mac_cmd_valid         = (state_q == ST_CLEAR) || (state_q == ST_ISSUE);
    assign mac_rsp_ready         = (state_q == ST_CLR_WAIT) || (state_q == ST_MWAIT);
    assign mac_func_id           = (state_q == ST_CLEAR) ? MAC_FN_CLEAR : MAC_FN_ACC;

    // Operands are zeroed outside a command so idle outputs stay quiet
    assign mac_in0 = (state_q == ST_CLEAR) ? {16'd0, offset_q} :
                     (state_q == ST_ISSUE) ? op_a_q : 32'd0;
    assign mac_in1 = (state_q == ST_ISSUE) ? op_b_q : 32'd0;

endmodule

// File: tb/tb_cfu_mac_sequencer.sv
// Directed bench for cfu_mac_sequencer with a behavioural int8x4 MAC engine
// and a one-cycle-latency operand buffer.
module tb_cfu_mac_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;
    logic        buf_rd_en;
    logic [9:0]  buf_rd_addr;
    logic [31:0] buf_rd_a;
    logic [31:0] buf_rd_b;
    logic        mac_cmd_valid;
    logic        mac_cmd_ready;
    logic [9:0]  mac_func_id;
    logic [31:0] mac_in0;
    logic [31:0] mac_in1;
    logic        mac_rsp_valid;
    logic        mac_rsp_ready;
    logic [31:0] mac_rsp_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cfu_mac_sequencer #(.ADDR_W(10), .LEN_W(12)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .buf_rd_en               (buf_rd_en),
        .buf_rd_addr             (buf_rd_addr),
        .buf_rd_a                (buf_rd_a),
        .buf_rd_b                (buf_rd_b),
        .mac_cmd_valid           (mac_cmd_valid),
        .mac_cmd_ready           (mac_cmd_ready),
        .mac_func_id             (mac_func_id),
        .mac_in0                 (mac_in0),
        .mac_in1                 (mac_in1),
        .mac_rsp_valid           (mac_rsp_valid),
        .mac_rsp_ready           (mac_rsp_ready),
        .mac_rsp_out             (mac_rsp_out)
    );

    // Operand buffer: one-cycle read latency
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    always @(posedge clk) begin
        if (buf_rd_en) begin
            buf_rd_a <= mem_a[buf_rd_addr];
            buf_rd_b <= mem_b[buf_rd_addr];
        end
    end

    // MAC engine: acc += sum over lanes of (a_i + offset) * b_i
    logic        m_rsp_q;
    logic [31:0] m_acc_q;
    logic [15:0] m_off_q;
    assign mac_cmd_ready = !m_rsp_q;
    assign mac_rsp_valid = m_rsp_q;
    assign mac_rsp_out   = m_acc_q;

    function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [15:0] off);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            logic signed [7:0]  av = a[8*i +: 8];
            logic signed [7:0]  bv = b[8*i +: 8];
            logic signed [15:0] ov = off;
            s += (int'(av) + int'(ov)) * int'(bv);
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_rsp_q <= 1'b0;
            m_acc_q <= 32'd0;
            m_off_q <= 16'd0;
        end else begin
            if (m_rsp_q && mac_rsp_ready) m_rsp_q <= 1'b0;
            if (mac_cmd_valid && mac_cmd_ready) begin
                m_rsp_q <= 1'b1;
                if (mac_func_id[2:0] == 3'd2) begin
                    m_acc_q <= 32'd0;
                    m_off_q <= mac_in0[15:0];
                end else begin
                    m_acc_q <= m_acc_q + dot4(mac_in0, mac_in1, m_off_q);
                end
            end
        end
    end

    // Traffic monitors
    int          n_clr = 0, n_mac = 0, n_rd = 0;
    logic [9:0]  rd_log0 = '0, rd_log1 = '0;
    always @(posedge clk) begin
        if (mac_cmd_valid && mac_cmd_ready) begin
            if (mac_func_id == 10'd2) n_clr <= n_clr + 1;
            else                      n_mac <= n_mac + 1;
        end
        if (buf_rd_en) begin
            n_rd    <= n_rd + 1;
            rd_log1 <= rd_log0;
            rd_log0 <= buf_rd_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [9:0] fid, input logic [31:0] in0, input logic [31:0] in1);
        int w = 0;
        while (!cmd_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_payload_function_id = fid;
        cmd_payload_inputs_0    = in0;
        cmd_payload_inputs_1    = in1;
        cmd_valid               = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 500) begin
            @(posedge clk); #1; cyc++;
        end
        chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    endtask

    task automatic accept(output logic [31:0] data);
        data      = rsp_payload_outputs_0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int          cyc;
        int          c_clr, c_mac, c_rd;
        logic [31:0] data;

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_payload_function_id = '0;
        cmd_payload_inputs_0 = '0;
        cmd_payload_inputs_1 = '0;
        rsp_ready = 1'b0;
        mem_a[0] = 32'h0101_0101; mem_b[0] = 32'h0202_0202;
        mem_a[1] = 32'h0101_0101; mem_b[1] = 32'h0202_0202;
        mem_a[2] = 32'h0101_0101; mem_b[2] = 32'h0202_0202;
        mem_a[1023] = 32'hFFFF_FFFF; mem_b[1023] = 32'h0303_0303;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_payload", rsp_payload_outputs_0, 32'd0);
        chk("rst_mac_valid", 32'(mac_cmd_valid), 32'd0);
        chk("rst_buf_en", 32'(buf_rd_en), 32'd0);
        chk("rst_mac_rsp_ready", 32'(mac_rsp_ready), 32'd0);

        // SET_OFF 128
        c_clr = n_clr; c_mac = n_mac; c_rd = n_rd;
        issue(10'd0, 32'd128, 32'd0);
        wait_valid(cyc);
        chk("setoff_lat", 32'(cyc), 32'd0);
        accept(data);
        chk("setoff_rsp", data, 32'd0);
        chk("setoff_no_mac", 32'(n_clr + n_mac - c_clr - c_mac), 32'd0);

        // RUN addr 0, N=1: 4*(1+128)*2
        c_clr = n_clr; c_mac = n_mac; c_rd = n_rd;
        issue(10'd1, 32'd0, 32'd1);
        wait_valid(cyc);
        chk("run1_lat", 32'(cyc), 32'd6);
        accept(data);
        chk("run1_rsp", data, 32'd1032);
        chk("run1_clr", 32'(n_clr - c_clr), 32'd1);
        chk("run1_mac", 32'(n_mac - c_mac), 32'd1);
        chk("run1_rd", 32'(n_rd - c_rd), 32'd1);

        // RUN addr 0, N=3
        c_clr = n_clr; c_mac = n_mac; c_rd = n_rd;
        issue(10'd1, 32'd0, 32'd3);
        wait_valid(cyc);
        chk("run3_lat", 32'(cyc), 32'd14);
        accept(data);
        chk("run3_rsp", data, 32'd3096);
        chk("run3_clr", 32'(n_clr - c_clr), 32'd1);
        chk("run3_mac", 32'(n_mac - c_mac), 32'd3);
        chk("run3_rd", 32'(n_rd - c_rd), 32'd3);

        // RUN N=0: upper count bits ignored (0x1000 -> 0)
        c_clr = n_clr; c_mac = n_mac; c_rd = n_rd;
        issue(10'd1, 32'd5, 32'h0000_1000);
        wait_valid(cyc);
        chk("run0_lat", 32'(cyc), 32'd2);
        accept(data);
        chk("run0_rsp", data, 32'd0);
        chk("run0_clr", 32'(n_clr - c_clr), 32'd1);
        chk("run0_mac", 32'(n_mac - c_mac), 32'd0);
        chk("run0_rd", 32'(n_rd - c_rd), 32'd0);

        // Address wrap: 1023 then 0; 4*(127*3) + 1032 = 2556
        issue(10'd1, 32'd1023, 32'd2);
        wait_valid(cyc);
        chk("wrap_lat", 32'(cyc), 32'd10);
        accept(data);
        chk("wrap_rsp", data, 32'd2556);
        chk("wrap_addr_first", 32'(rd_log1), 32'd1023);
        chk("wrap_addr_second", 32'(rd_log0), 32'd0);

        // Response back-pressure
        issue(10'd1, 32'd0, 32'd1);
        wait_valid(cyc);
        c_clr = n_clr; c_mac = n_mac; c_rd = n_rd;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_payload", rsp_payload_outputs_0, 32'd1032);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_mac_valid", 32'(mac_cmd_valid), 32'd0);
        end
        chk("hold_traffic", 32'(n_clr + n_mac + n_rd - c_clr - c_mac - c_rd), 32'd0);
        accept(data);
        chk("hold_rsp", data, 32'd1032);

        // Illegal opcode 5
        c_clr = n_clr; c_mac = n_mac; c_rd = n_rd;
        issue(10'd5, 32'd77, 32'd3);
        wait_valid(cyc);
        accept(data);
        chk("illegal_rsp", data, 32'hFFFF_FFFF);
        chk("illegal_traffic", 32'(n_clr + n_mac + n_rd - c_clr - c_mac - c_rd), 32'd0);

        // SET_OFF with upper function-id bits set, offset 0; RUN N=1 -> 8
        issue({7'h7F, 3'd0}, 32'hABCD_0000, 32'd0);
        wait_valid(cyc);
        accept(data);
        chk("setoff0_rsp", data, 32'd0);
        issue(10'd1, 32'd0, 32'd1);
        wait_valid(cyc);
        accept(data);
        chk("off0_run_rsp", data, 32'd8);

        // Reset while in MWAIT (offset 128 loaded first)
        issue(10'd0, 32'd128, 32'd0);
        wait_valid(cyc);
        accept(data);
        issue(10'd1, 32'd0, 32'd3);
        cyc = 0;
        while (!(mac_cmd_valid && mac_func_id == 10'd0) && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        chk("mwait_issue_seen", 32'(mac_cmd_valid), 32'd1);
        @(posedge clk); #1;
        chk("mwait_rsp_ready", 32'(mac_rsp_ready), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_payload", rsp_payload_outputs_0, 32'd0);
        chk("mrst_mac_valid", 32'(mac_cmd_valid), 32'd0);
        chk("mrst_mac_rsp_ready", 32'(mac_rsp_ready), 32'd0);
        chk("mrst_buf_en", 32'(buf_rd_en), 32'd0);
        chk("mrst_buf_addr", 32'(buf_rd_addr), 32'd0);
        chk("mrst_mac_in0", mac_in0, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Recovery: offset cleared by reset -> 4*1*2
        issue(10'd1, 32'd0, 32'd1);
        wait_valid(cyc);
        accept(data);
        chk("recover_rsp", data, 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
